// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: round-robin arbiter for 8 requesters.
// Grants are registered and one-hot, with a 3-bit encoded index. A requester
// keeps its grant while it holds req high. An optional hold timeout forcibly
// revokes long grants so that the other requesters are not starved.
module rr_arbiter_8 #(
  parameter int MAX_HOLD = 16,  // maximum grant length in cycles; 0 disables
  parameter int HOLD_W   = 16   // hold counter width; MAX_HOLD < 2**HOLD_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       En,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam bit              TIMEOUT_EN = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  state_t            state;
  logic [2:0]        ptr;
  logic [HOLD_W-1:0] hold_cnt;

  logic [2:0] cand;
  logic [2:0] win_idx;
  logic       win_found;
  logic       owner_req;
  logic       timeout_hit;
  logic       release_now;

  // Circular priority scan: first set req bit starting at ptr and wrapping.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cand      = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cand = ptr + 3'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Release decision while BUSY; a dropped request takes precedence over
  // a timeout on the same edge, so that case is a normal release.
  always_comb begin
    owner_req   = req[grant_idx];
    timeout_hit = TIMEOUT_EN && owner_req && (hold_cnt == HOLD_LAST);
    release_now = (state == BUSY) && (!owner_req || timeout_hit);
  end

  // Arbitration FSM with all outputs registered.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= 3'd0;
      hold_cnt    <= '0;
      grant       <= 8'h00;
      grant_idx   <= 3'd0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (En && win_found) begin
            state       <= BUSY;
            grant       <= 8'b1 << win_idx;
            grant_idx   <= win_idx;
            grant_valid <= 1'b1;
            hold_cnt    <= '0;
          end
        end
        BUSY: begin
          if (release_now) begin
            state       <= IDLE;
            ptr         <= grant_idx + 3'd1;
            grant       <= 8'h00;
            grant_idx   <= 3'd0;
            grant_valid <= 1'b0;
            timeout     <= timeout_hit;
          end else if (hold_cnt != '1) begin
            // Saturates only when the timeout is disabled.
            hold_cnt <= hold_cnt + HOLD_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8: scoreboard bench for rr_arbiter_8 (MAX_HOLD=4).
// The driver applies inputs on the falling edge, advances a behavioural model
// and queues the outputs expected after the next rising edge; a separate
// monitor pops and compares one entry per rising edge.
module tb_rr_arbiter_8;

  localparam int MAX_HOLD = 4;

  typedef struct packed {
    logic [7:0] grant;
    logic [2:0] idx;
    logic       valid;
    logic       tmo;
  } out_t;

  logic       clk;
  logic       rst_n;
  logic       En;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  out_t exp_q[$];

  // Behavioural model: current owner (-1 = none), cycles the grant has been
  // visible, and the requester that has first priority next time.
  int m_owner = -1;
  int m_held  = 0;
  int m_next  = 0;
  bit m_tmo   = 1'b0;

  rr_arbiter_8 #(.MAX_HOLD(MAX_HOLD), .HOLD_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .En         (En),
    .req        (req),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req_val);
    checks++;
    if (act !== req_val) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req_val, $time);
    end
  endtask

  function automatic out_t model_out();
    out_t o;
    o.grant = (m_owner >= 0) ? (8'(1) << m_owner) : 8'h00;
    o.idx   = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
    o.valid = (m_owner >= 0);
    o.tmo   = m_tmo;
    return o;
  endfunction

  // Advance the model across one rising edge with the given inputs.
  task automatic model_edge(input logic [7:0] r, input logic e, input logic rs);
    m_tmo = 1'b0;
    if (!rs) begin
      m_owner = -1;
      m_held  = 0;
      m_next  = 0;
    end else if (m_owner < 0) begin
      if (e && r != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          int c;
          c = (m_next + k) % 8;
          if (r[c]) begin
            m_owner = c;
            m_held  = 1;
            break;
          end
        end
      end
    end else if (!r[m_owner]) begin
      m_next  = (m_owner + 1) % 8;
      m_owner = -1;
    end else if (MAX_HOLD != 0 && m_held == MAX_HOLD) begin
      m_next  = (m_owner + 1) % 8;
      m_owner = -1;
      m_tmo   = 1'b1;
    end else begin
      m_held++;
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, move to next falling edge.
  task automatic step(input logic [7:0] r, input logic e, input logic rs = 1'b1);
    req   = r;
    En    = e;
    rst_n = rs;
    model_edge(r, e, rs);
    exp_q.push_back(model_out());
    @(negedge clk);
  endtask

  // Monitor: one comparison per rising edge while expectations are pending.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        out_t e;
        out_t a;
        e = exp_q.pop_front();
        a = '{grant, grant_idx, grant_valid, timeout};
        check("outputs{grant,idx,valid,timeout}", 32'(a), 32'(e));
      end
    end
  end

  initial begin
    logic [7:0] r;
    logic       e;
    logic       rs;

    // Reset held with every request active: no grant may appear.
    step(8'hFF, 1'b1, 1'b0);
    step(8'hFF, 1'b1, 1'b0);

    // Fairness: all requesting, each winner owns 2 cycles then drops its bit.
    for (int i = 0; i < 9; i++) begin
      int w;
      step(8'hFF, 1'b1);
      w = m_owner;
      check("fair_winner", 32'(w), 32'(i % 8));
      step(8'hFF, 1'b1);
      step(8'hFF & ~(8'(1) << w), 1'b1);
    end

    // Single requester 5, then release leaves ptr at 6.
    step(8'h20, 1'b1);
    step(8'h20, 1'b1);
    step(8'h00, 1'b1);
    check("ptr_after_5", 32'(m_next), 32'd6);

    // Timeout: requester 3 held permanently, then re-granted after one idle.
    for (int i = 0; i < 12; i++) step(8'h08, 1'b1);
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);
    // Request dropped exactly on the timeout edge: normal release.
    step(8'h08, 1'b1);
    step(8'h08, 1'b1);
    step(8'h08, 1'b1);
    step(8'h08, 1'b1);
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);

    // En gating: set ptr=1, En low blocks, then requester 7 beats 0.
    step(8'h01, 1'b1);
    step(8'h00, 1'b1);
    step(8'h81, 1'b0);
    step(8'h81, 1'b0);
    step(8'h81, 1'b1);
    step(8'h81, 1'b0);
    step(8'h01, 1'b0);
    step(8'h00, 1'b0);

    // Pointer skip: ptr=3, req=0101 wraps to 0, then ptr=1 gives 2.
    step(8'h04, 1'b1);
    step(8'h00, 1'b1);
    step(8'h05, 1'b1);
    step(8'h00, 1'b1);
    step(8'h05, 1'b1);
    step(8'h00, 1'b1);

    // Asynchronous reset mid-grant clears outputs before any clock edge.
    step(8'h08, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 32'({grant, grant_idx, grant_valid, timeout}), 32'd0);
    step(8'h08, 1'b1, 1'b0);
    step(8'h06, 1'b1);
    step(8'h00, 1'b1);

    // Randomised traffic with persistent requests and rare resets.
    r = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(2) == 0) r = 8'($urandom) & 8'($urandom);
      e  = ($urandom_range(3) != 0);
      rs = ($urandom_range(299) != 0);
      step(r, e, rs);
    end

    step(8'h00, 1'b1);
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
